// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the 16-bit sequencer and the 8-bit ALU it drives:
// operation codes, ALU command encodings, FSM states and a small helper.
package alu_ctrl_pkg;

  // 16-bit operations requested on the op port.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_XOR  = 2'b01,
    OP_SRL  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  // Command codes understood by the external combinational 8-bit ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Sequencer states. LO and HI are single-cycle ALU passes on one byte.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Zero flag for a 16-bit result.
  function automatic logic is_zero16(input logic [15:0] v);
    return (v == 16'h0000);
  endfunction

endpackage

// File: rtl/alu8.sv
// Zero-latency 8-bit ALU used beside alu_seq16. Pure combinational logic.
module alu8
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] cmd,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sc_i,
  output logic [7:0] rslt,
  output logic       sc_o
);

  // Decode the command; unused encodings produce zero.
  always_comb begin
    rslt = 8'h00;
    sc_o = 1'b0;
    case (cmd)
      ALU_ADD: {sc_o, rslt} = {1'b0, a} + {1'b0, b} + {8'h00, sc_i};
      ALU_XOR: rslt = a ^ b;
      ALU_SRL: begin
        rslt = {sc_i, a[7:1]};
        sc_o = a[0];
      end
      default: begin
        rslt = 8'h00;
        sc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq16.sv
// 16-bit ADD/XOR/SRL built from byte passes through an external 8-bit ALU.
//
// Handshake: start is sampled only while the FSM is in IDLE; that edge is the
// accept and latches op, a_in, b_in and shamt. busy is high from the cycle
// after accept through the DONE cycle inclusive. done is high for exactly the
// one DONE cycle. result, carry_out and zero are valid from done onward and
// hold until the next accept. start is ignored whenever busy is high.
module alu_seq16
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [3:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        zero,
  output logic [2:0]  alu_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_sc_i,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sc_o,
  output state_t      state_dbg
);

  state_t      state, state_next;
  op_t         op_in, op_q;
  logic [15:0] work;     // operand A, then partial results as passes complete
  logic [15:0] b_q;
  logic [3:0]  cnt;      // remaining SRL steps
  logic        carry;    // ADD carry between passes, SRL link bit
  logic        last_step;

  assign op_in     = op_t'(op);
  assign last_step = (cnt == 4'd1);
  assign state_dbg = state;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state sequencing for every operation.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op_in)
            OP_ADD, OP_XOR: state_next = S_LO;
            OP_SRL:         state_next = (shamt == 4'd0) ? S_DONE : S_HI;
            default:        state_next = S_DONE;
          endcase
        end
      end
      // ADD/XOR finish with HI; SRL steps are HI then LO.
      S_LO: begin
        if (op_q == OP_SRL) state_next = last_step ? S_DONE : S_HI;
        else                state_next = S_HI;
      end
      S_HI: begin
        if (op_q == OP_SRL) state_next = S_LO;
        else                state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ALU drive: quiet in IDLE/DONE, one byte slice per pass otherwise.
  always_comb begin
    alu_cmd  = ALU_ADD;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_sc_i = 1'b0;
    if (state == S_LO || state == S_HI) begin
      case (op_q)
        OP_ADD:  alu_cmd = ALU_ADD;
        OP_XOR:  alu_cmd = ALU_XOR;
        OP_SRL:  alu_cmd = ALU_SRL;
        default: alu_cmd = ALU_ADD;
      endcase
      if (state == S_LO) begin
        alu_a    = work[7:0];
        alu_b    = (op_q == OP_SRL) ? 8'h00 : b_q[7:0];
        alu_sc_i = (op_q == OP_SRL) ? carry : 1'b0;
      end else begin
        alu_a    = work[15:8];
        alu_b    = (op_q == OP_SRL) ? 8'h00 : b_q[15:8];
        alu_sc_i = (op_q == OP_ADD) ? carry : 1'b0;
      end
    end
  end

  // Datapath: latch operands on accept, capture ALU outputs at pass ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= OP_ADD;
      work      <= 16'h0000;
      b_q       <= 16'h0000;
      cnt       <= 4'd0;
      carry     <= 1'b0;
      result    <= 16'h0000;
      carry_out <= 1'b0;
      zero      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_in;
            work  <= a_in;
            b_q   <= b_in;
            cnt   <= shamt;
            carry <= 1'b0;
            // Operations that skip straight to DONE publish here.
            if (op_in == OP_RSVD) begin
              result    <= 16'h0000;
              carry_out <= 1'b0;
              zero      <= 1'b1;
            end else if (op_in == OP_SRL && shamt == 4'd0) begin
              result    <= a_in;
              carry_out <= 1'b0;
              zero      <= is_zero16(a_in);
            end
          end
        end
        S_LO: begin
          work[7:0] <= alu_rslt;
          carry     <= alu_sc_o;
          if (op_q == OP_SRL) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            if (last_step) begin
              result    <= {work[15:8], alu_rslt};
              carry_out <= alu_sc_o;
              zero      <= is_zero16({work[15:8], alu_rslt});
            end
          end
        end
        S_HI: begin
          if (op_q == OP_SRL) begin
            work[15:8] <= alu_rslt;
            carry      <= alu_sc_o;
          end else begin
            result    <= {alu_rslt, work[7:0]};
            carry_out <= (op_q == OP_ADD) ? alu_sc_o : 1'b0;
            zero      <= is_zero16({alu_rslt, work[7:0]});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq16.sv
// Directed bench for alu_seq16 with the alu8 slice beside it.
module tb_alu_seq16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [15:0] a_in, b_in;
  logic [3:0]  shamt;
  logic        busy, done, carry_out, zero;
  logic [15:0] result;
  logic [2:0]  alu_cmd;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_sc_i, alu_sc_o;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  alu_seq16 dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .shamt(shamt),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .zero(zero),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .state_dbg(state_dbg)
  );

  alu8 u_alu (
    .cmd(alu_cmd), .a(alu_a), .b(alu_b), .sc_i(alu_sc_i),
    .rslt(alu_rslt), .sc_o(alu_sc_o)
  );

  // Scoreboard check: every comparison goes through here.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one operation, scramble inputs after accept, wait for done.
  // hold_start keeps start high through busy and the DONE cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] sh, input bit hold_start,
                        input int exp_lat, input logic [15:0] exp_res,
                        input logic exp_c, input logic exp_z);
    int lat;
    op = o; a_in = a; b_in = b; shamt = sh; start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    a_in  = 16'($urandom_range(0, 65535));
    b_in  = 16'($urandom_range(0, 65535));
    shamt = 4'($urandom_range(0, 15));
    op    = 2'($urandom_range(0, 3));
    lat = 1;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
    check({tag, "_zero"}, 32'(zero), 32'(exp_z));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    check({tag, "_alu_quiet"}, 32'({alu_cmd, alu_a, alu_b, alu_sc_i}), 32'd0);
    tick();
    start = 1'b0;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'({busy, state_dbg}), 32'd0);
    check({tag, "_result_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int n_done;
    reset = 1'b1; start = 1'b0; op = 2'b00;
    a_in = 16'h0; b_in = 16'h0; shamt = 4'd0;
    repeat (3) tick();
    check("reset_flags", 32'({busy, done, carry_out, zero}), 32'b0001);
    check("reset_result", 32'(result), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_alu", 32'({alu_cmd, alu_a, alu_b, alu_sc_i}), 32'd0);
    reset = 1'b0;

    run_op("add_00ff_0001", 2'b00, 16'h00FF, 16'h0001, 4'd0, 1'b0, 3, 16'h0100, 1'b0, 1'b0);
    run_op("add_ffff_0001", 2'b00, 16'hFFFF, 16'h0001, 4'd0, 1'b0, 3, 16'h0000, 1'b1, 1'b1);
    run_op("add_1234_4321", 2'b00, 16'h1234, 16'h4321, 4'd0, 1'b0, 3, 16'h5555, 1'b0, 1'b0);
    run_op("add_7fff_8001", 2'b00, 16'h7FFF, 16'h8001, 4'd0, 1'b0, 3, 16'h0000, 1'b1, 1'b1);
    run_op("srl_8001_1", 2'b10, 16'h8001, 16'h0000, 4'd1, 1'b0, 3, 16'h4000, 1'b1, 1'b0);
    run_op("srl_8001_15", 2'b10, 16'h8001, 16'h0000, 4'd15, 1'b0, 31, 16'h0001, 1'b0, 1'b0);
    run_op("srl_f00f_4", 2'b10, 16'hF00F, 16'h0000, 4'd4, 1'b0, 9, 16'h0F00, 1'b1, 1'b0);
    run_op("xor_a5a5_ffff_hold", 2'b01, 16'hA5A5, 16'hFFFF, 4'd0, 1'b1, 3, 16'h5A5A, 1'b0, 1'b0);
    run_op("xor_equal", 2'b01, 16'h3C3C, 16'h3C3C, 4'd0, 1'b0, 3, 16'h0000, 1'b0, 1'b1);
    run_op("srl_1234_0", 2'b10, 16'h1234, 16'h0000, 4'd0, 1'b0, 1, 16'h1234, 1'b0, 1'b0);
    run_op("rsvd", 2'b11, 16'hBEEF, 16'hCAFE, 4'd7, 1'b0, 1, 16'h0000, 1'b0, 1'b1);

    // Reset mid-operation: SRL by 8, reset applied in cycle t+5.
    run_op("add_pre_abort", 2'b00, 16'h0100, 16'h0200, 4'd0, 1'b0, 3, 16'h0300, 1'b0, 1'b0);
    op = 2'b10; a_in = 16'h8001; b_in = 16'h0; shamt = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0;
    repeat (4) begin
      if (done) n_done++;
      tick();
    end
    check("abort_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_flags", 32'({busy, done, zero}), 32'b001);
    check("abort_result", 32'(result), 32'd0);
    check("abort_no_done", 32'(n_done), 32'd0);
    reset = 1'b0;
    run_op("add_after_reset", 2'b00, 16'h0001, 16'h0002, 4'd0, 1'b0, 3, 16'h0003, 1'b0, 1'b0);

    // Reset wins over start in the same cycle.
    reset = 1'b1; op = 2'b00; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("reset_beats_start", 32'({busy, state_dbg}), 32'd0);
    tick();
    check("reset_beats_start_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
